zbus_downsize: RTL and testbench
================================

# zbus_downsize

Single-clock zbus width down-converter that accepts one wide word per transfer on its input port and emits it as RN narrower beats on its output port, least-significant slice first. It sits directly downstream of the zbus async FIFO read port, in the consumer clock domain, and adapts the wide grouped bus to a narrow sink (serial link, byte-wide peripheral). Both ports use the zbus vld/ack handshake.

## Interface
- SW, 8: output slice width in bits (≥1)
- RN, 4: ratio, number of output beats per input word (≥1)
- BW, SW*RN: input bus width; derived, never overridden
- CNL, max(1,$clog2(RN)): beat counter width; derived
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- zi_vld  input  1  input transfer valid
- zi_bus  input  BW  input grouped bus word
- zi_ack  output  1  input transfer acknowledge
- zo_vld  output  1  output transfer valid
- zo_bus  output  SW  output slice
- zo_ack  input  1  output transfer acknowledge
- zo_lst  output  1  last beat of current word (only with ZBUS_DWN_LAST_EN)

## Operation
- Transfers: zi_trn = zi_vld & zi_ack; zo_trn = zo_vld & zo_ack.
- State: holding register buf[BW-1:0] (not reset), flag ful, counter cnt[CNL-1:0].
- Two states: EMPTY (ful=0), LOADED (ful=1).
- zo_vld = ful; zo_bus = buf[cnt*SW +: SW]; lst = (cnt == RN-1).
- zi_ack = rst & (~ful | (zo_trn & lst)); forced 0 while rst is low.
- EMPTY: on zi_trn → buf<=zi_bus, cnt<=0, ful<=1.
- LOADED, zo_trn & ~lst → cnt<=cnt+1, buf unchanged.
- LOADED, zo_trn & lst → cnt<=0; if zi_trn (same edge) buf<=zi_bus, ful stays 1; else ful<=0.
- LOADED, no zo_trn → hold everything; zo_vld and zo_bus stay stable until acknowledged.
- RN=1: block degenerates to a one-entry register slice; lst constant 1.
- cnt never exceeds RN-1; non-power-of-two RN wraps explicitly at RN-1, not by overflow.
- zo_vld never depends combinationally on zo_ack; zi_ack does (combinational path zo_ack→zi_ack, documented for timing).

## Timing
- Reset (rst=0 at a rising edge): ful=0, cnt=0 → zo_vld=0, zo_lst=0, zi_ack=0 during reset, zi_ack=1 in the first cycle after release.
- Reset mid-word: remaining beats are discarded; no zo_vld after reset until a new zi_trn.
- Latency: word accepted at edge k → first beat valid in cycle after k.
- Throughput: with zo_ack held 1 and zi_vld held 1, one beat every cycle, no bubbles between words (new word loaded on the same edge as last beat).
- Input stall: zi_vld low at the last beat → one or more empty cycles (zo_vld=0).

## Configuration
- ZBUS_DWN_LAST_EN defined: port zo_lst present, zo_lst = ful & lst.
- Undefined: port zo_lst absent; behaviour otherwise identical.

## Structure
- Shared package zbus_pkg: clog2-based width helper (max 1), zbus handshake transfer-function helpers, default SW/RN constants.
- No sub-module; single module with one always block for buf/cnt/ful.

## Test plan
- Reset: assert rst=0 for 3 cycles with zi_vld=1 → zi_ack=0, zo_vld=0; after release zi_ack=1.
- Single word SW=8, RN=4, zi_bus=32'hDDCCBBAA, zo_ack=1 → zo_bus AA,BB,CC,DD on 4 consecutive cycles, zo_lst only on DD, then zo_vld=0.
- Back-to-back words 32'h03020100, 32'h07060504 with zo_ack=1 → 8 contiguous beats 00..07, zi_ack high on the DD-equivalent (last) beat edge only.
- Output backpressure: zo_ack=0 for 5 cycles on beat 2 → zo_bus=8'h02 and zo_vld=1 held stable, zi_ack=0 throughout.
- Reset mid-word after 2 beats → zo_vld=0 next cycle, subsequent word 32'h0B0A0908 emits 08 first.
- RN=3, SW=4, random vld/ack over 1000 words → output stream equals scoreboard slices, cnt never reaches 3.

Source files
------------

// File: rtl/zbus_pkg.sv
// Shared zbus definitions: default widths, width helper and handshake helpers.
package zbus_pkg;

    localparam int unsigned ZBUS_SW_DEF = 8;
    localparam int unsigned ZBUS_RN_DEF = 4;

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_LOADED = 1'b1
    } zbus_dwn_state_e;

    // Counter width for n states; a zero-width counter is never wanted.
    function automatic int unsigned zbus_clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic zbus_trn(input logic vld, input logic ack);
        return vld & ack;
    endfunction

endpackage

// File: rtl/zbus_downsize_if.sv
// zbus vld/ack handshake bundle; the lst marker exists only with ZBUS_DWN_LAST_EN.
interface zbus_downsize_if #(
    parameter int unsigned W = 8
) ();

    logic         vld;
    logic [W-1:0] bus;
    logic         ack;
`ifdef ZBUS_DWN_LAST_EN
    logic         lst;
`endif

    modport master (
        output vld,
        output bus,
`ifdef ZBUS_DWN_LAST_EN
        output lst,
`endif
        input  ack
    );

    modport slave (
        input  vld,
        input  bus,
`ifdef ZBUS_DWN_LAST_EN
        input  lst,
`endif
        output ack
    );

endinterface

// File: rtl/zbus_downsize.sv
// zbus width down-converter: one BW-bit word in, RN SW-bit beats out, LS slice first.
// Optional zo.lst last-beat marker enabled by defining ZBUS_DWN_LAST_EN.
module zbus_downsize
    import zbus_pkg::*;
#(
    parameter int unsigned SW = ZBUS_SW_DEF,
    parameter int unsigned RN = ZBUS_RN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    zbus_downsize_if.slave  zi,
    zbus_downsize_if.master zo
);

    localparam int unsigned BW  = SW * RN;
    localparam int unsigned CNL = zbus_clog2_min1(RN);

    zbus_dwn_state_e state_q, state_d;
    logic [CNL-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]   buf_q, buf_d;

    logic            lst_c;
    logic            zo_vld_c;
    logic            zo_trn_c;
    logic            zi_ack_c;
    logic            zi_trn_c;
    logic [SW-1:0]   zo_bus_c;

    // State register; the data buffer is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
        buf_q <= buf_d;
    end

    // Output decode. zi_ack follows zo_ack combinationally so a new word
    // can load on the same edge as the last beat leaves.
    always_comb begin
        lst_c    = (cnt_q == CNL'(RN - 1));
        zo_vld_c = (state_q == ST_LOADED);
        zo_trn_c = zbus_trn(zo_vld_c, zo.ack);
        zi_ack_c = rst & (~zo_vld_c | (zo_trn_c & lst_c));
        zi_trn_c = zbus_trn(zi.vld, zi_ack_c);
        zo_bus_c = buf_q[int'(cnt_q) * SW +: SW];
    end

    // Next-state: beat counter wraps explicitly at RN-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (zi_trn_c) begin
                    buf_d   = zi.bus;
                    cnt_d   = '0;
                    state_d = ST_LOADED;
                end
            end
            ST_LOADED: begin
                if (zo_trn_c) begin
                    if (!lst_c) begin
                        cnt_d = cnt_q + CNL'(1);
                    end else begin
                        cnt_d = '0;
                        if (zi_trn_c) begin
                            buf_d = zi.bus;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    assign zi.ack = zi_ack_c;
    assign zo.vld = zo_vld_c;
    assign zo.bus = zo_bus_c;
`ifdef ZBUS_DWN_LAST_EN
    assign zo.lst = zo_vld_c & lst_c;
`endif

endmodule

// File: tb/tb_zbus_downsize.sv
// Bench for zbus_downsize: directed cases plus random traffic on SW=8/RN=4 and SW=4/RN=3.
module tb_zbus_downsize;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    int n_cmp = 0;
    int n_err = 0;
    int b_words = 0;
    bit b_done = 1'b0;

    always #5 clk = ~clk;

    zbus_downsize_if #(.W(32)) a_i ();
    zbus_downsize_if #(.W(8))  a_o ();
    zbus_downsize_if #(.W(12)) b_i ();
    zbus_downsize_if #(.W(4))  b_o ();

    zbus_downsize #(.SW(8), .RN(4)) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .zi  (a_i),
        .zo  (a_o)
    );

    zbus_downsize #(.SW(4), .RN(3)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .zi  (b_i),
        .zo  (b_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a queue of slices still owed on the output. The
    // converter holds at most one word, so it is acknowledged only when the
    // queue is empty or its final slice is leaving this cycle.
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always @(negedge clk) begin
        bit ev, ea;
        if (!rst_a) begin
            qa.delete();
            check("a_rst_ack", a_i.ack, 0);
        end else begin
            ev = (qa.size() != 0);
            ea = (qa.size() == 0) || (a_o.ack && qa.size() == 1);
            check("a_vld", a_o.vld, ev);
            if (ev) check("a_bus", a_o.bus, qa[0]);
`ifdef ZBUS_DWN_LAST_EN
            check("a_lst", a_o.lst, ev && qa.size() == 1);
`endif
            check("a_ack", a_i.ack, ea);
            if (ev && a_o.ack) void'(qa.pop_front());
            if (a_i.vld && ea)
                for (int k = 0; k < 4; k++) qa.push_back(a_i.bus[k*8 +: 8]);
        end
    end

    always @(negedge clk) begin
        bit ev, ea;
        if (!rst_b) begin
            qb.delete();
            check("b_rst_ack", b_i.ack, 0);
        end else begin
            ev = (qb.size() != 0);
            ea = (qb.size() == 0) || (b_o.ack && qb.size() == 1);
            check("b_vld", b_o.vld, ev);
            if (ev) check("b_bus", b_o.bus, qb[0]);
`ifdef ZBUS_DWN_LAST_EN
            check("b_lst", b_o.lst, ev && qb.size() == 1);
`endif
            check("b_ack", b_i.ack, ea);
            if (ev && b_o.ack) void'(qb.pop_front());
            if (b_i.vld && ea) begin
                for (int k = 0; k < 3; k++) qb.push_back({4'h0, b_i.bus[k*4 +: 4]});
                b_words++;
            end
        end
    end

    // Second instance: random vld/ack until 1000 words have been accepted.
    initial begin
        int cyc;
        rst_b     = 1'b0;
        b_i.vld   = 1'b0;
        b_i.bus   = '0;
        b_o.ack   = 1'b0;
        repeat (3) adv();
        rst_b = 1'b1;
        cyc   = 0;
        while (b_words < 1000 && cyc < 20000) begin
            adv();
            b_i.vld = ($urandom_range(0, 3) != 0);
            b_i.bus = 12'($urandom);
            b_o.ack = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        b_i.vld = 1'b0;
        b_o.ack = 1'b1;
        repeat (5) adv();
        b_done = (b_words >= 1000);
    end

    initial begin
        logic [31:0] w;
        logic [31:0] w1;
        int cyc;

        rst_a   = 1'b0;
        a_i.vld = 1'b1;
        a_i.bus = 32'h0;
        a_o.ack = 1'b0;

        // Reset held with input valid
        repeat (3) begin
            adv();
            @(negedge clk);
            check("rst_zi_ack", a_i.ack, 0);
            check("rst_zo_vld", a_o.vld, 0);
        end
        adv();
        rst_a   = 1'b1;
        a_i.vld = 1'b0;
        @(negedge clk);
        check("rel_zi_ack", a_i.ack, 1);
        check("rel_zo_vld", a_o.vld, 0);

        // Single word
        w = 32'hDDCCBBAA;
        adv();
        a_i.vld = 1'b1;
        a_i.bus = w;
        a_o.ack = 1'b1;
        @(negedge clk);
        check("single_ack", a_i.ack, 1);
        adv();
        a_i.vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("single_vld", a_o.vld, 1);
            check("single_bus", a_o.bus, w[i*8 +: 8]);
`ifdef ZBUS_DWN_LAST_EN
            check("single_lst", a_o.lst, i == 3);
`endif
            adv();
        end
        @(negedge clk);
        check("single_idle", a_o.vld, 0);

        // Back-to-back words
        adv();
        a_i.vld = 1'b1;
        a_i.bus = 32'h03020100;
        adv();
        a_i.bus = 32'h07060504;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("b2b_vld", a_o.vld, 1);
            check("b2b_bus", a_o.bus, j);
            check("b2b_ack", a_i.ack, (j == 3) || (j == 7));
            adv();
            if (j == 3) a_i.vld = 1'b0;
        end
        @(negedge clk);
        check("b2b_idle", a_o.vld, 0);

        // Output backpressure on beat 2
        adv();
        a_i.vld = 1'b1;
        a_i.bus = 32'h03020100;
        adv();
        w1 = 32'h0F0E0D0C;
        a_i.bus = w1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check("bp_pre_bus", a_o.bus, j);
            adv();
        end
        a_o.ack = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_vld", a_o.vld, 1);
            check("bp_hold_bus", a_o.bus, 8'h02);
            check("bp_hold_ack", a_i.ack, 0);
            adv();
        end
        a_o.ack = 1'b1;
        @(negedge clk);
        check("bp_rel_bus", a_o.bus, 8'h02);
        adv();
        @(negedge clk);
        check("bp_last_bus", a_o.bus, 8'h03);
        check("bp_last_ack", a_i.ack, 1);
        adv();
        a_i.vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_next_bus", a_o.bus, w1[i*8 +: 8]);
            adv();
        end

        // Reset mid-word
        a_i.vld = 1'b1;
        a_i.bus = 32'h13121110;
        adv();
        a_i.vld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mid_bus", a_o.bus, 8'h10 + 8'(i));
            adv();
        end
        rst_a = 1'b0;
        adv();
        rst_a = 1'b1;
        @(negedge clk);
        check("mid_rst_vld", a_o.vld, 0);
        adv();
        a_i.vld = 1'b1;
        a_i.bus = 32'h0B0A0908;
        adv();
        a_i.vld = 1'b0;
        @(negedge clk);
        check("mid_first_bus", a_o.bus, 8'h08);
        repeat (5) adv();

        // Random traffic on the first instance
        repeat (1500) begin
            a_i.vld = ($urandom_range(0, 2) != 0);
            a_i.bus = $urandom;
            a_o.ack = ($urandom_range(0, 3) != 0);
            adv();
        end
        a_i.vld = 1'b0;
        a_o.ack = 1'b1;
        repeat (6) adv();
        @(negedge clk);
        check("rand_a_drained", a_o.vld, 0);

        cyc = 0;
        while (!b_done && cyc < 30000) begin
            @(posedge clk);
            cyc++;
        end
        check("b_words_done", b_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
